// File: rtl/tc_timer.sv
// tc_timer: memory-mapped programmable down-counter timer for the peripheral
// bridge. Its interrupt request drives hwint[0].
//
// Register map (word select = byte address bits [3:2]):
//   0 CTRL   [0] EN, [2:1] MODE (00 one-shot, 01 auto-reload, 1x one-shot),
//            [3] IM. Bits [31:4] are not stored and read as 0.
//   1 PRESET reload value, copied into COUNT on each LOAD.
//   2 COUNT  current value; read-only.
//   3 reserved: writes ignored, reads return 0.
//
// Build option: define TC_AUTO_RELOAD_EN to make MODE = 01 reload the counter
// after every expiry. Without it the MODE bits are still stored and read back,
// but every expiry behaves as one-shot.
module tc_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;
  logic        auto_mode;
  logic        ctrl_wr;
  logic        preset_wr;

  assign ctrl_wr   = we && (addr == 2'd0);
  assign preset_wr = we && (addr == 2'd1);

`ifdef TC_AUTO_RELOAD_EN
  assign auto_mode = (ctrl[2:1] == 2'b01);
`else
  assign auto_mode = 1'b0;
`endif

  // The mask gates only the request line; the flag itself still records expiry.
  assign irq = ctrl[3] & irq_flag;

  // Counter FSM plus CPU register writes; a CPU CTRL write is applied last so it
  // overrides the one-shot EN clear and the flag set/clear on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ctrl     <= 4'd0;
      preset   <= 32'd0;
      count    <= 32'd0;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ctrl[0]) state <= LOAD;
        end
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!ctrl[0]) begin
            // Disabled mid-count: COUNT is held where it stopped.
            state <= IDLE;
          end else if (count > 32'd1) begin
            count <= count - 32'd1;
          end else begin
            // A count of 0 or 1 expires here, so PRESET = 0 acts like 1 and
            // the counter never wraps.
            count    <= 32'd0;
            irq_flag <= 1'b1;
            state    <= INT;
          end
        end
        INT: begin
          if (auto_mode) begin
            irq_flag <= 1'b0;
          end else begin
            ctrl[0] <= 1'b0;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (ctrl_wr) begin
        ctrl     <= din[3:0];
        irq_flag <= 1'b0;
      end
      // PRESET only feeds the next LOAD, so a running count is not disturbed.
      if (preset_wr) preset <= din;
    end
  end

  // Zero-latency read mux.
  always_comb begin
    dout = 32'd0;
    case (addr)
      2'd0:    dout = {28'd0, ctrl};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_tc_timer.sv
// tb_tc_timer: directed bench for tc_timer. An edge-indexed timeline model
// predicts COUNT and irq on every cycle; directed reads pin key values.
module tb_tc_timer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  addr = 2'd2;
  logic        we = 1'b0;
  logic [31:0] din = 32'd0;
  logic [31:0] dout;
  logic        irq;

  tc_timer dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  // Edge index: after rising edge number e, cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int INF = 1000000000;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // Timeline model: one enable segment at a time, described by the edge of the
  // enabling CTRL write, the preset captured for it, and the stop/clear edges.
  int          m_en_edge = INF;
  int          m_stop    = INF;
  int          m_clr     = INF;
  int unsigned m_n       = 0;
  logic [31:0] m_base    = 32'd0;
  logic [31:0] m_preset  = 32'd0;
  bit          m_im      = 1'b0;
  bit          m_auto    = 1'b0;

  function automatic int neff();
    return (m_n == 0) ? 1 : int'(m_n);
  endfunction

  // COUNT after edge e: preset loaded two edges after the enabling write, then
  // one decrement per edge down to 0; auto-reload repeats every neff+3 edges.
  function automatic logic [31:0] exp_count(input int e);
    int ee;
    int k;
    if (e < m_en_edge + 2) return m_base;
    ee = (e < m_stop) ? e : m_stop;
    if (ee < m_en_edge + 2) return m_base;
    k = ee - (m_en_edge + 2);
    if (m_auto) k = k % (neff() + 3);
    return (k >= int'(m_n)) ? 32'd0 : (m_n - k);
  endfunction

  // irq after edge e: expiry at en+2+neff unless disabled first.
  function automatic logic exp_irq(input int e);
    int x;
    x = m_en_edge + 2 + neff();
    if (!m_im || e < x || x >= m_stop) return 1'b0;
    if (m_auto) return (e < m_stop) && (((e - x) % (neff() + 3)) == 0);
    return e < m_clr;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h at edge %0d", name, got, expv, cyc);
  endtask

  // Per-cycle comparison against the model, well after the rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      chk("irq_model", {31'd0, irq}, {31'd0, exp_irq(cyc)});
      if (addr == 2'd2 && !we) chk("count_model", dout, exp_count(cyc));
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    int e;
    @(negedge clk);
    addr = a; we = 1'b1; din = d;
    @(posedge clk);
    #1;
    e = cyc;
    we = 1'b0; addr = 2'd2;
    if (a == 2'd1) begin
      m_preset = d;
    end else if (a == 2'd0) begin
      if (d[0]) begin
        m_base    = exp_count(e);
        m_en_edge = e;
        m_n       = m_preset;
        m_stop    = INF;
        m_clr     = INF;
        m_im      = d[3];
`ifdef TC_AUTO_RELOAD_EN
        m_auto    = (d[2:1] == 2'b01);
`else
        m_auto    = 1'b0;
`endif
      end else begin
        if (e < m_stop) m_stop = e;
        if (e < m_clr) m_clr = e;
      end
    end
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] expv, input string name);
    @(negedge clk);
    addr = a;
    #1;
    chk(name, dout, expv);
    addr = 2'd2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_en_edge = INF; m_stop = INF; m_clr = INF;
    m_n = 0; m_base = 32'd0; m_preset = 32'd0; m_im = 1'b0; m_auto = 1'b0;
  endtask

  task automatic at_edge(input int e);
    int g;
    g = 0;
    while (cyc < e && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    if (cyc != e) begin
      n_chk++;
      $display("FAIL at_edge: reached edge %0d required %0d", cyc, e);
    end
  endtask

  int t;
  int rises;
  logic prev;

  initial begin
    // Reset state and read-back of every address.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_en = 1'b1;
    chk("irq_after_reset", {31'd0, irq}, 32'd0);
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    rd(2'd3, 32'd0, "rst_reserved");
    wr(2'd2, 32'h0000_1234);
    wr(2'd3, 32'hFFFF_FFFF);
    rd(2'd2, 32'd0, "count_write_ignored");
    rd(2'd3, 32'd0, "reserved_write_ignored");

    // One-shot, PRESET = 5: irq at T+7, held until a CTRL write.
    do_reset();
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    t = cyc;
    at_edge(t + 6);
    chk("oneshot_irq_before", {31'd0, irq}, 32'd0);
    at_edge(t + 7);
    chk("oneshot_irq_rise", {31'd0, irq}, 32'd1);
    rd(2'd2, 32'd0, "oneshot_count_zero");
    at_edge(t + 9);
    rd(2'd0, 32'h8, "oneshot_ctrl_en_cleared");
    rd(2'd1, 32'd5, "oneshot_preset");
    at_edge(t + 12);
    chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
    wr(2'd0, 32'h0);
    chk("oneshot_irq_cleared", {31'd0, irq}, 32'd0);

    // MODE = 01, PRESET = 3: period 6 when auto-reload is built in.
    do_reset();
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    t = cyc;
    rises = 0;
    prev = irq;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (irq && !prev) rises++;
      prev = irq;
    end
`ifdef TC_AUTO_RELOAD_EN
    chk("auto_irq_rises", 32'(rises), 32'd3);
    rd(2'd0, 32'hB, "auto_ctrl_en_kept");
`else
    chk("auto_irq_rises", 32'(rises), 32'd1);
    rd(2'd0, 32'hA, "auto_ctrl_en_cleared");
`endif

    // Disable mid-count, re-enable, PRESET write mid-count, reset with irq high.
    do_reset();
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    t = cyc;
    at_edge(t + 6);
    wr(2'd0, 32'h8);
    at_edge(t + 10);
    rd(2'd2, 32'd5, "freeze_count");
    chk("freeze_no_irq", {31'd0, irq}, 32'd0);
    wr(2'd0, 32'h9);
    t = cyc;
    at_edge(t + 1);
    rd(2'd2, 32'd5, "reenable_before_load");
    at_edge(t + 2);
    rd(2'd2, 32'd10, "reenable_reload");
    at_edge(t + 4);
    wr(2'd1, 32'd2);
    rd(2'd2, 32'd7, "preset_write_midcount");
    at_edge(t + 12);
    chk("reenable_irq", {31'd0, irq}, 32'd1);
    do_reset();
    chk("reset_drops_irq", {31'd0, irq}, 32'd0);
    rd(2'd0, 32'd0, "reset_ctrl");
    rd(2'd2, 32'd0, "reset_count");
    rd(2'd1, 32'd0, "reset_preset");

    // PRESET = 0 behaves like 1: irq at T+3.
    do_reset();
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    t = cyc;
    at_edge(t + 2);
    chk("preset0_irq_before", {31'd0, irq}, 32'd0);
    at_edge(t + 3);
    chk("preset0_irq_rise", {31'd0, irq}, 32'd1);

    repeat (3) @(posedge clk);
    #3;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/tc_timer.md
# tc_timer

Memory-mapped programmable down-counter timer on the processor's peripheral bridge. It produces the interrupt request wired to bit 0 of the coprocessor-0 hardware-interrupt input (`hwint[0]`). The CPU programs it with store-word accesses and reads it with load-word accesses. It supports one-shot mode and, optionally, auto-reload mode.

## Interface
Parameters:
- none

Ports:
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `addr`, input, 2: word select (byte address bits [3:2]). 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we`, input, 1: write enable from the bridge; sampled at the clock edge.
- `din`, input, 32: write data.
- `dout`, output, 32: read data; combinational from `addr`.
- `irq`, output, 1: interrupt request to `hwint[0]`; equals `ctrl[3] & irq_flag`.

## Operation
Registers:
- CTRL:
  - [0] EN (enable).
  - [2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
  - [3] IM (interrupt mask).
  - [31:4] are not stored and read as 0.
- PRESET: 32-bit reload value.
- COUNT: 32-bit current value. It is read-only; writes to it are ignored.
- Writes to address 3 are ignored. Reads of address 3 return 0.

Writes:
- A write to CTRL stores `din[3:0]` and clears `irq_flag`.
- A write to PRESET never disturbs a count in progress. The new value takes effect at the next LOAD.

State machine (`state`, 2 bits). Transitions use the CTRL value held before the edge.
- IDLE: if EN = 1, go to LOAD.
- LOAD: COUNT <= PRESET; go to CNT.
- CNT:
  - If EN = 0, go to IDLE. COUNT is held.
  - Else if COUNT > 1, COUNT <= COUNT - 1.
  - Else (COUNT is 1 or 0), COUNT <= 0, `irq_flag` <= 1, go to INT.
- INT, MODE = one-shot:
  - EN <= 0.
  - `irq_flag` stays 1 until a CTRL write or reset.
  - Go to IDLE.
- INT, MODE = auto-reload:
  - `irq_flag` <= 0, so the flag is a 1-cycle pulse.
  - EN is unchanged.
  - Go to IDLE, which reloads on the next edge.

Conflicts and boundaries:
- If a CPU write to CTRL and the one-shot EN clear happen on the same edge, the CPU write wins.
- PRESET = 0 behaves like PRESET = 1: INT is reached after 1 CNT cycle.
- COUNT never wraps below 0.
- The mask affects `irq` only. When IM = 0, `irq_flag` still sets, and setting IM = 1 later cannot raise `irq` because any CTRL write clears the flag.

## Timing
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, `irq_flag` = 0, `irq` = 0. `dout` is 0 for every address.
- Read latency is 0 cycles; `dout` is combinational.
- Let the CTRL write with EN = 1 occur at edge T, with PRESET = N ≥ 1:
  - Edge T+1: state is LOAD.
  - Edge T+2: COUNT = N, state is CNT.
  - Edge T+k+2: COUNT = N−k.
  - Edge T+N+2: state is INT and `irq` rises.
- Auto-reload period is N+3 cycles: INT, IDLE, LOAD, then N CNT cycles. `irq` is high for exactly 1 cycle per period.
- Writing EN = 0 at edge E during CNT: the edge after E enters IDLE with COUNT frozen.
- Reset asserted mid-count: at that edge, all registers return to their reset values and `irq` drops.

## Configuration
- `TC_AUTO_RELOAD_EN` defined: MODE = 01 selects auto-reload as described above.
- `TC_AUTO_RELOAD_EN` undefined:
  - MODE bits still read back as written.
  - MODE is ignored; every expiry behaves as one-shot.

## Test plan
- Reset, then read addresses 0, 1, 2, 3 -> each read is 0x0000_0000; `irq` = 0.
- PRESET = 5, then CTRL = 0x9 (EN, IM, one-shot) at edge T:
  - `irq` rises at edge T+7 and COUNT reads 0.
  - CTRL reads 0x8.
  - `irq` stays high until a CTRL write of 0x0, then drops at that edge.
- PRESET = 3, CTRL = 0xB (auto-reload), with the macro defined -> `irq` pulses for 1 cycle every 6 cycles; EN stays 1.
- Same stimulus with the macro undefined -> exactly one `irq` assertion; EN cleared.
- Counting from PRESET = 10:
  - Write CTRL = 0x8 when COUNT = 6 -> COUNT freezes at 5 or 6 depending on the edge, and no `irq`.
  - Re-enable with CTRL = 0x9 -> COUNT reloads to 10.
- PRESET = 0 with EN set -> `irq` at edge T+3.
- A PRESET write mid-count does not change COUNT.
- `reset` asserted with `irq` high -> `irq` = 0 and CTRL = 0 after that edge.
